// File: rtl/switch_allocator.sv
// Crossbar output-port allocator: round-robin arbitration per output with
// wormhole locking and per-(output,VC) credit gating.
module switch_allocator #(
  parameter int unsigned NUM_OUTPORTS = 4,
  parameter int unsigned NUM_BUFFERS  = 4,
  parameter int unsigned NUM_VCS      = 2,
  parameter int unsigned VC_DEPTH     = 8,
  localparam int unsigned OW = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
  localparam int unsigned BW = (NUM_BUFFERS  > 1) ? $clog2(NUM_BUFFERS)  : 1,
  localparam int unsigned VW = (NUM_VCS      > 1) ? $clog2(NUM_VCS)      : 1,
  localparam int unsigned CW = $clog2(VC_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic [NUM_BUFFERS-1:0]                 req_valid,
  input  logic [NUM_BUFFERS-1:0][OW-1:0]         req_outport,
  input  logic [NUM_BUFFERS-1:0][VW-1:0]         req_vc,
  input  logic [NUM_BUFFERS-1:0]                 req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   credit_granted,
  output logic [NUM_BUFFERS-1:0]                 grant,
  output logic [NUM_OUTPORTS-1:0]                out_valid,
  output logic [NUM_OUTPORTS-1:0][BW-1:0]        out_sel,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   credit_avail,
  output logic                                   credit_err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_st_e;

  lock_st_e [NUM_OUTPORTS-1:0]                  lock_st_q;
  logic     [NUM_OUTPORTS-1:0][BW-1:0]          lock_in_q;
  logic     [NUM_OUTPORTS-1:0][VW-1:0]          lock_vc_q;
  logic     [NUM_OUTPORTS-1:0][BW-1:0]          rr_ptr_q;
  logic     [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CW-1:0] credit_q;
  logic                                         credit_err_q;

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0]     elig;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]         cred_dec;

  always_comb begin
    elig = '0;
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        elig[o][i] = req_valid[i] && (req_outport[i] == OW'(o)) &&
                     (credit_q[o][req_vc[i]] != '0) &&
                     ((lock_st_q[o] == IDLE) ||
                      ((lock_in_q[o] == BW'(i)) && (lock_vc_q[o] == req_vc[i])));
      end
    end
  end

  // A locked output only ever has its lock holder eligible, so the same
  // rotating scan serves both the locked and unlocked cases.
  always_comb begin : arbitrate
    logic          found;
    logic [BW-1:0] idx;
    out_valid = '0;
    out_sel   = '0;
    grant     = '0;
    cred_dec  = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_BUFFERS; k++) begin
        idx = BW'((32'(rr_ptr_q[o]) + k) % NUM_BUFFERS);
        if (!found && elig[o][idx]) begin
          found      = 1'b1;
          out_sel[o] = idx;
        end
      end
      if (found && n_rst) begin
        out_valid[o]                     = 1'b1;
        grant[out_sel[o]]                = 1'b1;
        cred_dec[o][req_vc[out_sel[o]]]  = 1'b1;
      end else begin
        out_sel[o] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lock_st_q    <= {NUM_OUTPORTS{IDLE}};
      lock_in_q    <= '0;
      lock_vc_q    <= '0;
      rr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
      for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
          credit_q[o][v] <= CW'(VC_DEPTH);
        end
      end
    end else begin
      for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
        if (out_valid[o]) begin
          if (req_tail[out_sel[o]]) begin
            lock_st_q[o] <= IDLE;
            rr_ptr_q[o]  <= BW'((32'(out_sel[o]) + 1) % NUM_BUFFERS);
          end else if (lock_st_q[o] == IDLE) begin
            lock_st_q[o] <= LOCKED;
            lock_in_q[o] <= out_sel[o];
            lock_vc_q[o] <= req_vc[out_sel[o]];
          end
        end
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
          if (credit_granted[o][v] && !cred_dec[o][v]) begin
            if (credit_q[o][v] == CW'(VC_DEPTH)) begin
              credit_err_q <= 1'b1;
            end else begin
              credit_q[o][v] <= credit_q[o][v] + 1'b1;
            end
          end else if (cred_dec[o][v] && !credit_granted[o][v]) begin
            credit_q[o][v] <= credit_q[o][v] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    credit_avail = '0;
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        credit_avail[o][v] = (credit_q[o][v] != '0);
      end
    end
  end

  assign credit_err = credit_err_q;

endmodule
